// File: rtl/router_pkg.sv
// Shared definitions for the router port reader: header field layout,
// reader FSM encoding and the running parity helper.
package router_pkg;

   localparam int HDR_LEN_MSB = 7;
   localparam int HDR_LEN_LSB = 2;
   localparam int HDR_ADDR_W  = 2;
   localparam int HDR_LEN_W   = HDR_LEN_MSB - HDR_LEN_LSB + 1;

   typedef enum logic [1:0] {
      HDR = 2'd0,
      PAY = 2'd1,
      PAR = 2'd2
   } rd_state_e;

   // Packet parity is the XOR of header and payload bytes.
   function automatic logic [7:0] parity_acc(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/router_skid_buf.sv
// Small synchronous FIFO with fall-through head: a push into an empty
// buffer is visible on head_data in the same cycle it is pushed.
module router_skid_buf #(
   parameter int DEPTH = 2,
   parameter int W     = 10,
   parameter int OCC_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [W-1:0]     push_data,
   input  logic             pop,
   output logic             head_valid,
   output logic [W-1:0]     head_data,
   output logic [OCC_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] cnt_q, cnt_d;
   logic             empty;
   logic             bypass;
   logic             do_write;
   logic             do_read;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty      = (cnt_q == '0);
   // Push and pop of the same byte into an empty buffer never touches storage.
   assign bypass     = empty && push && pop;
   assign do_write   = push && !bypass;
   assign do_read    = pop && !empty;
   assign head_valid = !empty || push;
   assign head_data  = empty ? push_data : mem_q[rd_ptr_q];
   assign count      = cnt_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q + OCC_W'(do_write) - OCC_W'(do_read);
      if (do_write) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_read) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/router_port_reader.sv
// Drains one router output-port FIFO into a ready/valid byte stream with
// sop/eop markers, re-checks packet parity and reports per-packet status.
module router_port_reader
   import router_pkg::*;
#(
   parameter logic [HDR_ADDR_W-1:0] PORT_ADDR = 2'd0,
   parameter int                    BUF_DEPTH = 2,
   parameter int                    CNT_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  vld_out,
   input  logic [7:0]            d_out,
   output logic                  rd_enb,
   output logic [7:0]            m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_sop,
   output logic                  m_eop,
   output logic                  stat_valid,
   output logic [HDR_LEN_W-1:0]  stat_len,
   output logic [HDR_ADDR_W-1:0] stat_addr,
   output logic                  stat_parity_err,
   output logic                  stat_addr_err,
   output logic [CNT_W-1:0]      pkt_count
);

   localparam int OCC_W = $clog2(BUF_DEPTH + 1);
   localparam int TAG_W = 10;

   // Read side and push-side packet tagging
   logic                 rd_inflight_q, rd_inflight_d;
   logic [OCC_W-1:0]     occ;
   logic [OCC_W:0]       reserved;
   logic                 push_hdr_q, push_hdr_d;
   logic [HDR_LEN_W:0]   push_rem_q, push_rem_d;
   logic                 tag_sop, tag_eop;
   logic                 head_valid;
   logic [TAG_W-1:0]     head_data;
   logic                 xfer;

   // Head-side parser
   rd_state_e            state_q, state_d;
   logic                 hdr_xfer, pay_xfer, par_xfer;
   logic [HDR_LEN_W-1:0] len_q, len_d;
   logic [HDR_ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]           par_q, par_d;
   logic [HDR_LEN_W-1:0] rem_q, rem_d;
   logic                 stat_valid_q, stat_valid_d;
   logic [HDR_LEN_W-1:0] stat_len_q, stat_len_d;
   logic [HDR_ADDR_W-1:0] stat_addr_q, stat_addr_d;
   logic                 stat_perr_q, stat_perr_d;
   logic                 stat_aerr_q, stat_aerr_d;
   logic [CNT_W-1:0]     pkt_cnt_q, pkt_cnt_d;

   // Bytes already requested but not yet landed still count against space.
   assign reserved      = {1'b0, occ} + {{OCC_W{1'b0}}, rd_inflight_q};
   assign rd_enb        = vld_out && (reserved < (OCC_W + 1)'(BUF_DEPTH));
   assign rd_inflight_d = rd_enb;

   assign tag_sop = push_hdr_q;
   assign tag_eop = !push_hdr_q && (push_rem_q == (HDR_LEN_W + 1)'(1));

   always_comb begin
      push_hdr_d = push_hdr_q;
      push_rem_d = push_rem_q;
      if (rd_inflight_q) begin
         if (push_hdr_q) begin
            push_hdr_d = 1'b0;
            push_rem_d = {1'b0, d_out[HDR_LEN_MSB:HDR_LEN_LSB]} + (HDR_LEN_W + 1)'(1);
         end else begin
            push_rem_d = push_rem_q - (HDR_LEN_W + 1)'(1);
            push_hdr_d = (push_rem_q == (HDR_LEN_W + 1)'(1));
         end
      end
   end

   router_skid_buf #(
      .DEPTH (BUF_DEPTH),
      .W     (TAG_W),
      .OCC_W (OCC_W)
   ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .push       (rd_inflight_q),
      .push_data  ({tag_sop, tag_eop, d_out}),
      .pop        (xfer),
      .head_valid (head_valid),
      .head_data  (head_data),
      .count      (occ)
   );

   assign m_valid = head_valid;
   assign m_data  = head_valid ? head_data[7:0] : 8'h00;
   assign m_sop   = head_valid && head_data[9];
   assign m_eop   = head_valid && head_data[8];
   assign xfer    = head_valid && m_ready;

   always_ff @(posedge clk) begin
      if (rst) state_q <= HDR;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         HDR: if (xfer) state_d = (m_data[HDR_LEN_MSB:HDR_LEN_LSB] != '0) ? PAY : PAR;
         PAY: if (xfer && rem_q == HDR_LEN_W'(1)) state_d = PAR;
         PAR: if (xfer) state_d = HDR;
         default: state_d = HDR;
      endcase
   end

   always_comb begin
      hdr_xfer = xfer && (state_q == HDR);
      pay_xfer = xfer && (state_q == PAY);
      par_xfer = xfer && (state_q == PAR);
   end

   always_comb begin
      len_d        = len_q;
      addr_d       = addr_q;
      par_d        = par_q;
      rem_d        = rem_q;
      stat_valid_d = 1'b0;
      stat_len_d   = stat_len_q;
      stat_addr_d  = stat_addr_q;
      stat_perr_d  = stat_perr_q;
      stat_aerr_d  = stat_aerr_q;
      pkt_cnt_d    = pkt_cnt_q;
      if (hdr_xfer) begin
         len_d  = m_data[HDR_LEN_MSB:HDR_LEN_LSB];
         addr_d = m_data[HDR_ADDR_W-1:0];
         par_d  = parity_acc(8'h00, m_data);
         rem_d  = m_data[HDR_LEN_MSB:HDR_LEN_LSB];
      end
      if (pay_xfer) begin
         par_d = parity_acc(par_q, m_data);
         rem_d = rem_q - HDR_LEN_W'(1);
      end
      if (par_xfer) begin
         stat_valid_d = 1'b1;
         stat_len_d   = len_q;
         stat_addr_d  = addr_q;
         stat_perr_d  = (par_q != m_data);
         stat_aerr_d  = (addr_q != PORT_ADDR);
         pkt_cnt_d    = pkt_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_inflight_q <= 1'b0;
         push_hdr_q    <= 1'b1;
         push_rem_q    <= '0;
         len_q         <= '0;
         addr_q        <= '0;
         par_q         <= '0;
         rem_q         <= '0;
         stat_valid_q  <= 1'b0;
         stat_len_q    <= '0;
         stat_addr_q   <= '0;
         stat_perr_q   <= 1'b0;
         stat_aerr_q   <= 1'b0;
         pkt_cnt_q     <= '0;
      end else begin
         rd_inflight_q <= rd_inflight_d;
         push_hdr_q    <= push_hdr_d;
         push_rem_q    <= push_rem_d;
         len_q         <= len_d;
         addr_q        <= addr_d;
         par_q         <= par_d;
         rem_q         <= rem_d;
         stat_valid_q  <= stat_valid_d;
         stat_len_q    <= stat_len_d;
         stat_addr_q   <= stat_addr_d;
         stat_perr_q   <= stat_perr_d;
         stat_aerr_q   <= stat_aerr_d;
         pkt_cnt_q     <= pkt_cnt_d;
      end
   end

   assign stat_valid      = stat_valid_q;
   assign stat_len        = stat_len_q;
   assign stat_addr       = stat_addr_q;
   assign stat_parity_err = stat_perr_q;
   assign stat_addr_err   = stat_aerr_q;
   assign pkt_count       = pkt_cnt_q;

endmodule

// File: tb/tb_router_port_reader.sv
// Bench for router_port_reader: models the router port FIFO as a byte queue
// and scores the stream and status outputs against per-packet expectations.
module tb_router_port_reader;

   localparam logic [1:0] PORT_ADDR = 2'd0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vld_out;
   logic [7:0]  d_out;
   logic        rd_enb;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_sop;
   logic        m_eop;
   logic        stat_valid;
   logic [5:0]  stat_len;
   logic [1:0]  stat_addr;
   logic        stat_parity_err;
   logic        stat_addr_err;
   logic [15:0] pkt_count;

   router_port_reader #(.PORT_ADDR(PORT_ADDR), .BUF_DEPTH(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .vld_out(vld_out), .d_out(d_out), .rd_enb(rd_enb),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_sop(m_sop),
      .m_eop(m_eop), .stat_valid(stat_valid), .stat_len(stat_len),
      .stat_addr(stat_addr), .stat_parity_err(stat_parity_err),
      .stat_addr_err(stat_addr_err), .pkt_count(pkt_count)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // ---------------- scoreboard state ----------------
   int         total = 0;
   int         bad = 0;
   logic [7:0] fifo_q[$];
   logic [9:0] exp_q[$];
   logic [9:0] exp_stat_q[$];
   logic [7:0] pkt_b[$];
   int         ready_mode = 0;
   int         seen_pkts = 0;
   int         xfer_cnt = 0;
   int         outst = 0;
   int         last_sop_cyc = 0;
   int         last_eop_cyc = 0;
   int         sop_gap = 0;
   logic       prev_stall = 1'b0;
   logic [9:0] prev_head = '0;
   logic       rd_s;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- router FIFO model ----------------
   initial begin
      vld_out = 1'b0;
      d_out   = 8'h00;
      rd_s    = 1'b0;
      forever begin
         @(negedge clk);
         rd_s = rd_enb && vld_out && !rst;
         @(posedge clk);
         #1;
         if (rd_s && fifo_q.size() != 0) d_out = fifo_q.pop_front();
         vld_out = !rst && (fifo_q.size() != 0);
      end
   end

   // ---------------- sink ready driver ----------------
   initial begin
      m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: m_ready = 1'b1;
            1: m_ready = ((cyc % 3) == 0);
            2: m_ready = 1'($urandom_range(0, 1));
            default: ;
         endcase
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rst) begin
         outst      = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check_eq("hold_valid", m_valid, 1);
            check_eq("hold_head", {m_sop, m_eop, m_data}, prev_head);
         end
         if (m_valid && m_ready) begin
            xfer_cnt++;
            if (exp_q.size() == 0) check_eq("unexpected_byte", 32'(exp_q.size()), 1);
            else                   check_eq("stream", {m_sop, m_eop, m_data}, exp_q.pop_front());
            if (m_sop) begin
               sop_gap      = cyc - last_eop_cyc;
               last_sop_cyc = cyc;
            end
            if (m_eop) last_eop_cyc = cyc;
         end
         if (rd_enb && vld_out) outst++;
         if (m_valid && m_ready) outst--;
         if (rd_enb || m_valid) check_eq("occupancy_le_2", (outst <= 2), 1);
         prev_stall = m_valid && !m_ready;
         prev_head  = {m_sop, m_eop, m_data};
         if (stat_valid) begin
            seen_pkts++;
            if (exp_stat_q.size() == 0) check_eq("unexpected_stat", 32'(exp_stat_q.size()), 1);
            else check_eq("stat", {stat_len, stat_addr, stat_parity_err, stat_addr_err}, exp_stat_q.pop_front());
            check_eq("pkt_count", pkt_count, seen_pkts);
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Expectations come from the packet bytes: len/addr from the header,
   // parity error when the XOR of header+payload differs from the last byte.
   task automatic push_pkt();
      logic [7:0] x;
      int         last;
      last = pkt_b.size() - 1;
      x    = 8'h00;
      for (int i = 0; i < last; i++) x = x ^ pkt_b[i];
      for (int i = 0; i <= last; i++) begin
         exp_q.push_back({(i == 0), (i == last), pkt_b[i]});
         fifo_q.push_back(pkt_b[i]);
      end
      exp_stat_q.push_back({pkt_b[0][7:2], pkt_b[0][1:0], (x != pkt_b[last]), (pkt_b[0][1:0] != PORT_ADDR)});
   endtask

   task automatic rand_pkt(input int len, input int addr, input bit bad_par);
      logic [7:0] x;
      logic [7:0] b;
      pkt_b.delete();
      b = {6'(len), 2'(addr)};
      x = b;
      pkt_b.push_back(b);
      for (int i = 0; i < len; i++) begin
         b = 8'($urandom_range(0, 255));
         x = x ^ b;
         pkt_b.push_back(b);
      end
      if (bad_par) x = x ^ (8'h01 << $urandom_range(0, 7));
      pkt_b.push_back(x);
      push_pkt();
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || exp_stat_q.size() != 0) && n < 20000) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      check_eq({tag, "_drained"}, 32'(exp_q.size() + exp_stat_q.size()), 0);
   endtask

   task automatic check_reset_outs(input string tag);
      check_eq({tag, "_m_valid"}, m_valid, 0);
      check_eq({tag, "_m_data"}, m_data, 0);
      check_eq({tag, "_m_sop_eop"}, {m_sop, m_eop}, 0);
      check_eq({tag, "_rd_enb"}, rd_enb, 0);
      check_eq({tag, "_stat_valid"}, stat_valid, 0);
      check_eq({tag, "_stat_fields"}, {stat_len, stat_addr, stat_parity_err, stat_addr_err}, 0);
      check_eq({tag, "_pkt_count"}, pkt_count, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int xb;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outs("reset");
      @(posedge clk);
      #1 rst = 1'b0;

      // Nominal packet, streamed on consecutive cycles.
      pkt_b = '{8'h08, 8'hA5, 8'h3C, 8'h91};
      push_pkt();
      wait_drain("nominal");
      check_eq("nominal_span", 32'(last_eop_cyc - last_sop_cyc), 3);
      check_eq("nominal_count", pkt_count, 1);

      // Bad parity, then held flag, then a good packet clears it.
      pkt_b = '{8'h08, 8'hA5, 8'h3C, 8'h90};
      push_pkt();
      wait_drain("badpar");
      repeat (3) @(negedge clk);
      check_eq("badpar_hold", stat_parity_err, 1);
      pkt_b = '{8'h08, 8'hA5, 8'h3C, 8'h91};
      push_pkt();
      wait_drain("goodpar");
      check_eq("goodpar_clear", stat_parity_err, 0);

      // Zero length with address mismatch.
      pkt_b = '{8'h01, 8'h01};
      push_pkt();
      wait_drain("zerolen");
      check_eq("zerolen_span", 32'(last_eop_cyc - last_sop_cyc), 1);
      check_eq("zerolen_addr_err", stat_addr_err, 1);

      // Backpressure with m_ready pattern 1,0,0.
      @(posedge clk);
      #1 ready_mode = 1;
      rand_pkt(4, 0, 1'b0);
      wait_drain("backpressure");

      // Back-to-back packets.
      @(posedge clk);
      #1 ready_mode = 0;
      rand_pkt(3, 0, 1'b0);
      rand_pkt(1, 2, 1'b0);
      wait_drain("b2b");
      check_eq("b2b_sop_gap", sop_gap, 1);

      // Randomized traffic with random sink readiness, including max length.
      @(posedge clk);
      #1 ready_mode = 2;
      rand_pkt(63, 0, 1'b0);
      for (int i = 0; i < 24; i++)
         rand_pkt($urandom_range(0, 63), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
      wait_drain("random");

      // Reset after header + one payload byte have transferred.
      @(posedge clk);
      #1 ready_mode = 3;
      m_ready = 1'b0;
      rand_pkt(5, 0, 1'b0);
      repeat (6) @(posedge clk);
      xb = xfer_cnt;
      #1 m_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 m_ready = 1'b0;
      @(negedge clk);
      check_eq("prereset_xfers", 32'(xfer_cnt - xb), 2);
      @(posedge clk);
      #1 rst = 1'b1;
      fifo_q.delete();
      exp_q.delete();
      exp_stat_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outs("midreset");
      @(posedge clk);
      #1 rst = 1'b0;
      seen_pkts  = 0;
      ready_mode = 0;
      repeat (8) @(negedge clk);
      check_eq("post_reset_no_stat", pkt_count, 0);
      rand_pkt(2, 0, 1'b0);
      wait_drain("fresh");
      check_eq("fresh_count", pkt_count, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
